conv_mac_20: RTL and testbench
==============================

CONV_MAC_20 -- requirements
Module: conv_mac_20

Interface
REQ-001 SHALL have parameter COEFF_W, default `coeff_width, signed weight width.
REQ-002 SHALL have parameter DATA_W, default 16, signed activation width.
REQ-003 SHALL have parameter KERN_S, default `kern_s_20, weight/activation pairs per output (>=1).
REQ-004 SHALL have parameter OUT_W, default 16, signed result width.
REQ-005 SHALL derive localparam ACC_W = COEFF_W+DATA_W+$clog2(KERN_S)+1.
REQ-006 SHALL have port ap_clk, in, 1, single clock; all state updates on its rising edge.
REQ-007 SHALL have port ap_rst, in, 1, reset, synchronous and active-high.
REQ-008 SHALL have port weight_V_dout, in, COEFF_W, weight stream data from the weight ROM streamer.
REQ-009 SHALL have port weight_V_empty_n, in, 1, weight stream has data.
REQ-010 SHALL have port weight_V_read, out, 1, weight pop strobe.
REQ-011 SHALL have port input_V_dout, in, DATA_W, activation stream data.
REQ-012 SHALL have port input_V_empty_n, in, 1, activation stream has data.
REQ-013 SHALL have port input_V_read, out, 1, activation pop strobe.
REQ-014 SHALL have port output_V_din, out, OUT_W, saturated dot-product result.
REQ-015 SHALL have port output_V_full_n, in, 1, downstream can accept.
REQ-016 SHALL have port output_V_write, out, 1, result valid/push strobe.

Function
REQ-017 SHALL implement two states: ACC (consuming pairs) and OUT (presenting result).
REQ-018 In ACC, weight_V_read and input_V_read SHALL both equal weight_V_empty_n AND input_V_empty_n (combinational), and both SHALL be 0 in OUT; the two streams are never popped separately.
REQ-019 On each cycle with reads asserted, SHALL add the signed full-precision product weight_V_dout*input_V_dout, sign-extended to ACC_W, to the accumulator and increment pair counter.
REQ-020 Cycles in ACC without reads SHALL leave accumulator and counter unchanged (starvation stalls, no data loss).
REQ-021 On the read cycle with counter == KERN_S-1, SHALL register output_V_din = sat(acc + product), clear the counter, and enter OUT next cycle; latency last pop -> output_V_write high = 1 cycle.
REQ-022 sat() SHALL clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; in-range values pass unchanged (no rounding, no shift).
REQ-023 In OUT, output_V_write SHALL be 1 and output_V_din SHALL be held stable until a cycle with output_V_full_n = 1.
REQ-024 A transfer SHALL occur on each cycle with output_V_write AND output_V_full_n; on that edge SHALL clear the accumulator, drop output_V_write, and return to ACC, so reads may resume on the next cycle.
REQ-025 Exactly one transfer SHALL occur per KERN_S consumed pairs; output_V_write SHALL never be 1 in ACC.
REQ-026 With KERN_S = 1, every pop SHALL produce a result; ACC/OUT alternation is unchanged.
REQ-027 Accumulator SHALL not overflow internally for any KERN_S input values (guaranteed by ACC_W).

Reset
REQ-028 When ap_rst is 1 at a rising edge, SHALL set state ACC, counter 0, accumulator 0, output_V_din 0, output_V_write 0.
REQ-029 Reads SHALL be 0 during any cycle ap_rst is 1.
REQ-030 Reset mid-window or in OUT SHALL discard the partial sum or pending result; the next window starts from zero pairs.

Verification (KERN_S=4, COEFF_W=8, DATA_W=8, OUT_W=8)
REQ-031 Weights {1,2,3,4}, activations {1,1,1,1}, both always non-empty, full_n=1 -> reads high 4 consecutive cycles, output_V_write high 1 cycle later for 1 cycle, din = 10.
REQ-032 Weights {127,127,127,127}, activations {127,...} -> din = 127; weights {-128,...}, activations {127,...} -> din = -128.
REQ-033 Activation empty_n low 3 cycles after 2 pops, weight non-empty -> both reads 0 for those cycles, result still exact sum of the 4 pairs.
REQ-034 full_n low 5 cycles while in OUT -> write held 1, din stable, no reads; on full_n high one transfer, reads resume next cycle, next window result excludes prior sum.
REQ-035 ap_rst pulsed after 2 pops of {5,5}x{1,1}, then {1,1,1,1}x{1,1,1,1} -> din = 4, output_V_write 0 during and right after reset.
REQ-036 Back-to-back windows with continuous streams -> write pattern: 4 read cycles, 1 OUT cycle, repeating; no pair dropped or duplicated.

Source files
------------

// File: rtl/conv_mac_20.sv
// conv_mac_20 -- streaming signed dot-product engine for one convolution tap set.
//
// Pops a weight and an activation together, accumulates KERN_S signed
// products at full precision, then presents the saturated OUT_W-bit result
// on a FIFO-style write port until the downstream accepts it.
//
// Ports:
//   ap_clk           in   1        clock, all state updates on rising edge
//   ap_rst           in   1        synchronous active-high reset
//   weight_V_dout    in   COEFF_W  signed weight stream data
//   weight_V_empty_n in   1        weight stream has data
//   weight_V_read    out  1        weight pop strobe
//   input_V_dout     in   DATA_W   signed activation stream data
//   input_V_empty_n  in   1        activation stream has data
//   input_V_read     out  1        activation pop strobe
//   output_V_din     out  OUT_W    saturated dot-product result
//   output_V_full_n  in   1        downstream can accept
//   output_V_write   out  1        result valid / push strobe

`ifndef COEFF_WIDTH
`define COEFF_WIDTH 8
`endif
`ifndef KERN_S_20
`define KERN_S_20 4
`endif

module conv_mac_20 #(
  parameter int COEFF_W = `COEFF_WIDTH,
  parameter int DATA_W  = 16,
  parameter int KERN_S  = `KERN_S_20,
  parameter int OUT_W   = 16
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic [COEFF_W-1:0] weight_V_dout,
  input  logic               weight_V_empty_n,
  output logic               weight_V_read,
  input  logic [DATA_W-1:0]  input_V_dout,
  input  logic               input_V_empty_n,
  output logic               input_V_read,
  output logic [OUT_W-1:0]   output_V_din,
  input  logic               output_V_full_n,
  output logic               output_V_write
);

  localparam int ACC_W  = COEFF_W + DATA_W + $clog2(KERN_S) + 1;
  localparam int PROD_W = COEFF_W + DATA_W;
  localparam int CNT_W  = (KERN_S > 1) ? $clog2(KERN_S) : 1;
  // Wide enough to hold both the accumulator and the clamp bounds signed.
  localparam int EXT_W  = ACC_W + OUT_W;

  localparam logic [0:0] ST_ACC = 1'b0;
  localparam logic [0:0] ST_OUT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KERN_S - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic signed [EXT_W-1:0] SAT_MAX =
    {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN =
    {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Clamp a full-precision sum into the signed OUT_W range.
  function automatic logic [OUT_W-1:0] sat_fn(input logic signed [ACC_W-1:0] v);
    logic signed [EXT_W-1:0] v_ext;
    v_ext = {{(EXT_W-ACC_W){v[ACC_W-1]}}, v};
    if (v_ext > SAT_MAX) begin
      sat_fn = SAT_MAX[OUT_W-1:0];
    end else if (v_ext < SAT_MIN) begin
      sat_fn = SAT_MIN[OUT_W-1:0];
    end else begin
      sat_fn = v_ext[OUT_W-1:0];
    end
  endfunction

  logic [0:0]               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [OUT_W-1:0]         dout_q, dout_d;

  logic                     pop_s;
  logic signed [PROD_W-1:0] w_ext_s, a_ext_s, prod_s;
  logic signed [ACC_W-1:0]  sum_s;

  // Both streams pop together, only in ACC and never while reset is held.
  assign pop_s = (state_q == ST_ACC) && weight_V_empty_n && input_V_empty_n && !ap_rst;
  assign weight_V_read = pop_s;
  assign input_V_read  = pop_s;

  // Operands are sign-extended to the product width so the multiply is exact.
  assign w_ext_s = {{DATA_W{weight_V_dout[COEFF_W-1]}}, weight_V_dout};
  assign a_ext_s = {{COEFF_W{input_V_dout[DATA_W-1]}}, input_V_dout};
  assign prod_s  = w_ext_s * a_ext_s;
  assign sum_s   = acc_q + {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};

  assign output_V_din   = dout_q;
  assign output_V_write = (state_q == ST_OUT);

  // Next-state logic for the ACC/OUT window sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    case (state_q)
      ST_ACC: begin
        if (pop_s) begin
          if (cnt_q == CNT_LAST) begin
            // Final pair folds straight into the result register.
            dout_d  = sat_fn(sum_s);
            acc_d   = sum_s;
            cnt_d   = '0;
            state_d = ST_OUT;
          end else begin
            acc_d   = sum_s;
            cnt_d   = cnt_q + CNT_ONE;
            state_d = ST_ACC;
          end
        end else begin
          // Starved: hold everything.
          acc_d   = acc_q;
          cnt_d   = cnt_q;
          state_d = ST_ACC;
        end
      end
      ST_OUT: begin
        if (output_V_full_n) begin
          acc_d   = '0;
          state_d = ST_ACC;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_ACC;
        cnt_d   = '0;
        acc_d   = '0;
        dout_d  = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= ST_ACC;
      cnt_q   <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: tb/tb_conv_mac_20.sv
// tb_conv_mac_20 -- directed self-checking bench for conv_mac_20
// (KERN_S=4, COEFF_W=8, DATA_W=8, OUT_W=8). The bench owns small stream
// queues that feed the DUT and pops them whenever the DUT strobes a read.

module tb_conv_mac_20;

  logic              ap_clk;
  logic              ap_rst;
  logic [7:0]        weight_V_dout;
  logic              weight_V_empty_n;
  logic              weight_V_read;
  logic [7:0]        input_V_dout;
  logic              input_V_empty_n;
  logic              input_V_read;
  logic [7:0]        output_V_din;
  logic              output_V_full_n;
  logic              output_V_write;

  int checks;
  int failures;

  logic signed [7:0] wq[$];
  logic signed [7:0] aq[$];
  logic signed [7:0] res[$];
  logic [7:0]        din_log[$];
  logic              a_hold;
  logic [31:0]       rd_vec;
  logic [31:0]       wr_vec;
  int                tick_n;

  conv_mac_20 #(
    .COEFF_W(8),
    .DATA_W (8),
    .KERN_S (4),
    .OUT_W  (8)
  ) dut (
    .ap_clk          (ap_clk),
    .ap_rst          (ap_rst),
    .weight_V_dout   (weight_V_dout),
    .weight_V_empty_n(weight_V_empty_n),
    .weight_V_read   (weight_V_read),
    .input_V_dout    (input_V_dout),
    .input_V_empty_n (input_V_empty_n),
    .input_V_read    (input_V_read),
    .output_V_din    (output_V_din),
    .output_V_full_n (output_V_full_n),
    .output_V_write  (output_V_write)
  );

  // Free-running 10-unit clock.
  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  // Present queue heads to the DUT.
  task automatic drive();
    weight_V_empty_n = (wq.size() > 0);
    weight_V_dout    = (wq.size() > 0) ? wq[0] : 8'sd0;
    input_V_empty_n  = (aq.size() > 0) && !a_hold;
    input_V_dout     = (aq.size() > 0) ? aq[0] : 8'sd0;
  endtask

  task automatic clear_log();
    rd_vec = 32'd0;
    wr_vec = 32'd0;
    tick_n = 0;
    res.delete();
    din_log.delete();
  endtask

  // One clock cycle: sample strobes, clock, pop/record, re-drive.
  task automatic tick();
    logic rd;
    logic wr;
    logic fn;
    logic [7:0] d;
    #1;
    rd = weight_V_read;
    wr = output_V_write;
    fn = output_V_full_n;
    d  = output_V_din;
    checks++;
    if (weight_V_read !== input_V_read) begin
      failures++;
      $display("FAIL read_pair t=%0d weight_read=%b input_read=%b", tick_n, weight_V_read, input_V_read);
    end
    checks++;
    if (wr === 1'b1 && rd === 1'b1) begin
      failures++;
      $display("FAIL read_in_out t=%0d write=%b read=%b required read=0", tick_n, wr, rd);
    end
    rd_vec[tick_n] = (rd === 1'b1);
    wr_vec[tick_n] = (wr === 1'b1);
    din_log.push_back(d);
    @(posedge ap_clk);
    #1;
    if (rd === 1'b1) begin
      void'(wq.pop_front());
      void'(aq.pop_front());
    end
    if (wr === 1'b1 && fn === 1'b1) res.push_back(d);
    tick_n++;
    drive();
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    wq = '{8'sd9, 8'sd9};
    aq = '{8'sd9, 8'sd9};
    drive();
    tick();
    clear_log();
    tick();
    tick();
    checks++;
    if (rd_vec[1:0] !== 2'b00) begin
      failures++;
      $display("FAIL reset_reads got=%b required=00", rd_vec[1:0]);
    end
    checks++;
    if (output_V_write !== 1'b0) begin
      failures++;
      $display("FAIL reset_write got=%b required=0", output_V_write);
    end
    checks++;
    if (output_V_din !== 8'd0) begin
      failures++;
      $display("FAIL reset_din got=%0d required=0", output_V_din);
    end
    ap_rst = 1'b0;
    wq.delete();
    aq.delete();
    drive();
    tick();
  endtask

  task automatic test_basic();
    clear_log();
    wq = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    aq = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};
    drive();
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (rd_vec[7:0] !== 8'h0F) begin
      failures++;
      $display("FAIL basic_reads got=%b required=00001111", rd_vec[7:0]);
    end
    checks++;
    if (wr_vec[7:0] !== 8'h10) begin
      failures++;
      $display("FAIL basic_write got=%b required=00010000", wr_vec[7:0]);
    end
    checks++;
    if (res.size() !== 1 || res[0] !== 8'sd10) begin
      failures++;
      $display("FAIL basic_din count=%0d got=%0d required=10", res.size(), (res.size() > 0) ? res[0] : 8'sd0);
    end
  endtask

  task automatic test_saturation();
    clear_log();
    wq = '{8'sd127, 8'sd127, 8'sd127, 8'sd127, -8'sd128, -8'sd128, -8'sd128, -8'sd128};
    aq = '{8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127};
    drive();
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (rd_vec[11:0] !== 12'h1EF || wr_vec[11:0] !== 12'h210) begin
      failures++;
      $display("FAIL sat_pattern reads=%h writes=%h required reads=1ef writes=210", rd_vec[11:0], wr_vec[11:0]);
    end
    checks++;
    if (res.size() !== 2 || res[0] !== 8'sd127) begin
      failures++;
      $display("FAIL sat_pos count=%0d got=%0d required=127", res.size(), (res.size() > 0) ? res[0] : 8'sd0);
    end
    checks++;
    if (res.size() !== 2 || res[1] !== -8'sd128) begin
      failures++;
      $display("FAIL sat_neg count=%0d got=%0d required=-128", res.size(), (res.size() > 1) ? res[1] : 8'sd0);
    end
  endtask

  task automatic test_stall();
    clear_log();
    // 3*4 + (-2)*7 + 5*(-1) + 1*2 = -5
    wq = '{8'sd3, -8'sd2, 8'sd5, 8'sd1};
    aq = '{8'sd4, 8'sd7, -8'sd1, 8'sd2};
    drive();
    tick();
    tick();
    a_hold = 1'b1;
    drive();
    for (int i = 0; i < 3; i++) tick();
    a_hold = 1'b0;
    drive();
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (rd_vec[8:0] !== 9'h063) begin
      failures++;
      $display("FAIL stall_reads got=%b required=001100011", rd_vec[8:0]);
    end
    checks++;
    if (wr_vec[8:0] !== 9'h080) begin
      failures++;
      $display("FAIL stall_write got=%b required=010000000", wr_vec[8:0]);
    end
    checks++;
    if (res.size() !== 1 || res[0] !== -8'sd5) begin
      failures++;
      $display("FAIL stall_din count=%0d got=%0d required=-5", res.size(), (res.size() > 0) ? res[0] : 8'sd0);
    end
  endtask

  task automatic test_backpressure();
    clear_log();
    output_V_full_n = 1'b0;
    wq = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd2, 8'sd2, 8'sd2, 8'sd2};
    aq = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1};
    drive();
    for (int i = 0; i < 9; i++) tick();
    output_V_full_n = 1'b1;
    drive();
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (rd_vec[15:0] !== 16'h3C0F) begin
      failures++;
      $display("FAIL bp_reads got=%h required=3c0f", rd_vec[15:0]);
    end
    checks++;
    if (wr_vec[15:0] !== 16'h43F0) begin
      failures++;
      $display("FAIL bp_write got=%h required=43f0", wr_vec[15:0]);
    end
    for (int i = 4; i < 10; i++) begin
      checks++;
      if (din_log[i] !== 8'd4) begin
        failures++;
        $display("FAIL bp_din_hold t=%0d got=%0d required=4", i, din_log[i]);
      end
    end
    checks++;
    if (res.size() !== 2 || res[0] !== 8'sd4 || res[1] !== 8'sd8) begin
      failures++;
      $display("FAIL bp_results count=%0d required count=2 values 4,8", res.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    wq = '{8'sd5, 8'sd5};
    aq = '{8'sd1, 8'sd1};
    drive();
    tick();
    tick();
    ap_rst = 1'b1;
    wq = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};
    aq = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};
    drive();
    tick();
    ap_rst = 1'b0;
    drive();
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (rd_vec[8:0] !== 9'h07B) begin
      failures++;
      $display("FAIL rstmid_reads got=%b required=001111011", rd_vec[8:0]);
    end
    checks++;
    if (wr_vec[8:0] !== 9'h080) begin
      failures++;
      $display("FAIL rstmid_write got=%b required=010000000", wr_vec[8:0]);
    end
    checks++;
    if (res.size() !== 1 || res[0] !== 8'sd4) begin
      failures++;
      $display("FAIL rstmid_din count=%0d got=%0d required=4", res.size(), (res.size() > 0) ? res[0] : 8'sd0);
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    // Window w: weights 4w+1..4w+4 against {1,2,1,2} -> 24w+16.
    for (int i = 0; i < 12; i++) begin
      wq.push_back(8'(i + 1));
      aq.push_back(((i % 2) == 0) ? 8'sd1 : 8'sd2);
    end
    drive();
    for (int i = 0; i < 16; i++) tick();
    checks++;
    if (rd_vec[15:0] !== 16'h3DEF) begin
      failures++;
      $display("FAIL b2b_reads got=%h required=3def", rd_vec[15:0]);
    end
    checks++;
    if (wr_vec[15:0] !== 16'h4210) begin
      failures++;
      $display("FAIL b2b_write got=%h required=4210", wr_vec[15:0]);
    end
    checks++;
    if (res.size() !== 3 || res[0] !== 8'sd16 || res[1] !== 8'sd40 || res[2] !== 8'sd64) begin
      failures++;
      $display("FAIL b2b_results count=%0d required count=3 values 16,40,64", res.size());
    end
  endtask

  // Test sequence.
  initial begin
    checks          = 0;
    failures        = 0;
    a_hold          = 1'b0;
    ap_rst          = 1'b1;
    output_V_full_n = 1'b1;
    clear_log();
    drive();
    test_reset();
    test_basic();
    test_saturation();
    test_stall();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
